instr_fetch_mem: RTL and testbench

Parametrised instruction-fetch memory for the RV32IM pipeline's IF stage. It owns the program counter and a word-addressed instruction ROM/RAM, and delivers one registered instruction per cycle with its PC and a valid flag. It supports stall, branch/jump redirect with flush, a program-load write port, and a fault flag for misaligned or out-of-range fetches. The decoder (ID stage) consumes its outputs directly.

---
 rtl/instr_fetch_mem.sv | 101 ++++++++++
 tb/tb_instr_fetch_mem.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_mem.sv
// instr_fetch_mem
//   IF-stage fetch unit: owns the program counter and a word-addressed
//   instruction memory. It presents one registered instruction per cycle
//   together with its byte PC, a valid flag and a fault flag.
//
// Parameters
//   DEPTH_WORDS : number of 32-bit words (power of two, >= 2)
//   RESET_PC    : PC loaded on reset
//   INIT_FILE   : optional image name; memory starts all NOP
//   NOP_INSTR   : bubble instruction (ADDI x0,x0,0)
//
// Ports
//   clk            : rising-edge clock
//   reset          : asynchronous active-high reset
//   stall          : hold PC and all outputs
//   redirect_valid : taken branch/jump, load redirect_pc and flush
//   redirect_pc    : redirect target (byte address)
//   load_en        : program-load write strobe
//   load_addr      : byte address of the word to write (bits [1:0] ignored)
//   load_data      : word to write
//   instr          : fetched instruction
//   instr_pc       : byte address of instr
//   instr_valid    : instr is a real fetch, not a bubble
//   fetch_fault    : this fetch was misaligned or out of range
module instr_fetch_mem #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter string       INIT_FILE   = "",
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    output logic        fetch_fault
);

    localparam int unsigned IDX = $clog2(DEPTH_WORDS);

    logic [31:0]    mem [DEPTH_WORDS] = '{default: NOP_INSTR};
    logic [31:0]    pc;
    logic [IDX-1:0] fetch_idx;
    logic [IDX-1:0] load_idx;
    logic           fetch_bad;
    logic           load_in_range;
    logic           unused_load_lsbs;

    // Depth is a power of two, so "word index >= DEPTH_WORDS" is simply
    // "any address bit above the index field is set".
    always_comb begin
        fetch_idx     = pc[IDX+1:2];
        load_idx      = load_addr[IDX+1:2];
        fetch_bad     = (pc[1:0] != 2'b00) || (pc[31:IDX+2] != '0);
        load_in_range = (load_addr[31:IDX+2] == '0);
    end

    assign unused_load_lsbs = ^load_addr[1:0];

    // Memory carries no reset; a load is ignored while reset is asserted
    // so that reset keeps its priority over load_en.
    always_ff @(posedge clk) begin
        if (load_en && !reset && load_in_range) begin
            mem[load_idx] <= load_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            instr       <= NOP_INSTR;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            fetch_fault <= 1'b0;
        end else if (load_en) begin
            // Load slot is a bubble; pc and instr_pc hold, any redirect is dropped.
            instr       <= NOP_INSTR;
            instr_valid <= 1'b0;
            fetch_fault <= 1'b0;
        end else if (redirect_valid) begin
            // Flush the slot; instr_pc keeps the last delivered address.
            pc          <= redirect_pc;
            instr       <= NOP_INSTR;
            instr_valid <= 1'b0;
            fetch_fault <= 1'b0;
        end else if (!stall) begin
            instr       <= fetch_bad ? NOP_INSTR : mem[fetch_idx];
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            fetch_fault <= fetch_bad;
            pc          <= pc + 32'd4;
        end
    end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// tb_instr_fetch_mem
//   Directed, table-driven bench for instr_fetch_mem. Each vector sets the
//   inputs for one clock edge and lists the outputs expected just after it.
//   Hand-written sequences cover the asynchronous reset cases.
module tb_instr_fetch_mem;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] ADD = 32'h0020_81B3;
    localparam logic [31:0] SUB = 32'h4020_8233;
    localparam logic [31:0] SW  = 32'h0030_2023;
    localparam logic [31:0] LW  = 32'h0000_2283;
    localparam logic [31:0] ADI = 32'h00A0_0093;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        fetch_fault;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        st;
        logic        rv;
        logic [31:0] rpc;
        logic        le;
        logic [31:0] la;
        logic [31:0] ld;
        logic [31:0] ei;
        logic [31:0] ep;
        logic        ev;
        logic        ef;
    } vec_t;

    vec_t vq[$];

    instr_fetch_mem #(
        .DEPTH_WORDS(1024),
        .RESET_PC   (32'h0000_0000),
        .INIT_FILE  (""),
        .NOP_INSTR  (NOP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .load_en       (load_en),
        .load_addr     (load_addr),
        .load_data     (load_data),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .fetch_fault   (fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int idx, input logic [31:0] ei, input logic [31:0] ep,
                           input logic ev, input logic ef);
        chk({tag, ".instr"}, idx, instr, ei);
        chk({tag, ".instr_pc"}, idx, instr_pc, ep);
        chk({tag, ".valid"}, idx, {31'd0, instr_valid}, {31'd0, ev});
        chk({tag, ".fault"}, idx, {31'd0, fetch_fault}, {31'd0, ef});
    endtask

    task automatic add(input logic st, input logic rv, input logic [31:0] rpc,
                       input logic le, input logic [31:0] la, input logic [31:0] ld,
                       input logic [31:0] ei, input logic [31:0] ep, input logic ev, input logic ef);
        vec_t v;
        v.st = st; v.rv = rv; v.rpc = rpc; v.le = le; v.la = la; v.ld = ld;
        v.ei = ei; v.ep = ep; v.ev = ev; v.ef = ef;
        vq.push_back(v);
    endtask

    task automatic idle_inputs();
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
    endtask

    // Apply vectors [first, last]: drive just after an edge, check just after the next.
    task automatic run_vecs(input string tag, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            stall = vq[i].st; redirect_valid = vq[i].rv; redirect_pc = vq[i].rpc;
            load_en = vq[i].le; load_addr = vq[i].la; load_data = vq[i].ld;
            @(posedge clk); #1;
            chk_all(tag, i, vq[i].ei, vq[i].ep, vq[i].ev, vq[i].ef);
        end
        idle_inputs();
    endtask

    initial begin
        //  st   rv   rpc            le   la           ld             instr         pc             v     f
        // Program load after the first reset (bubbles, instr_pc held at 0): vectors 0..4
        add(1'b0,1'b0,32'h0,         1'b1,32'h00,      ADD,           NOP,          32'h0,         1'b0,1'b0);
        add(1'b0,1'b0,32'h0,         1'b1,32'h04,      SUB,           NOP,          32'h0,         1'b0,1'b0);
        add(1'b0,1'b0,32'h0,         1'b1,32'h08,      SW,            NOP,          32'h0,         1'b0,1'b0);
        add(1'b0,1'b0,32'h0,         1'b1,32'h0C,      LW,            NOP,          32'h0,         1'b0,1'b0);
        add(1'b0,1'b0,32'h0,         1'b1,32'h40,      ADI,           NOP,          32'h0,         1'b0,1'b0);
        // Run after async reset; stall 3 cycles at instr_pc=4: vectors 5..10
        add(1'b0,1'b0,32'h0,         1'b0,32'h0,       32'h0,         ADD,          32'h0,         1'b1,1'b0);
        add(1'b0,1'b0,32'h0,         1'b0,32'h0,       32'h0,         SUB,          32'h4,         1'b1,1'b0);
        add(1'b1,1'b0,32'h0,         1'b0,32'h0,       32'h0,         SUB,          32'h4,         1'b1,1'b0);
        add(1'b1,1'b0,32'h0,         1'b0,32'h0,       32'h0,         SUB,          32'h4,         1'b1,1'b0);
        add(1'b1,1'b0,32'h0,         1'b0,32'h0,       32'h0,         SUB,          32'h4,         1'b1,1'b0);
        add(1'b0,1'b0,32'h0,         1'b0,32'h0,       32'h0,         SW,           32'h8,         1'b1,1'b0);
        // Redirect with stall high at instr_pc=8: 11..13
        add(1'b1,1'b1,32'h40,        1'b0,32'h0,       32'h0,         NOP,          32'h8,         1'b0,1'b0);
        add(1'b0,1'b0,32'h0,         1'b0,32'h0,       32'h0,         ADI,          32'h40,        1'b1,1'b0);
        add(1'b0,1'b0,32'h0,         1'b0,32'h0,       32'h0,         NOP,          32'h44,        1'b1,1'b0);
        // Back to 0 and four free cycles: 14..18
        add(1'b0,1'b1,32'h0,         1'b0,32'h0,       32'h0,         NOP,          32'h44,        1'b0,1'b0);
        add(1'b0,1'b0,32'h0,         1'b0,32'h0,       32'h0,         ADD,          32'h0,         1'b1,1'b0);
        add(1'b0,1'b0,32'h0,         1'b0,32'h0,       32'h0,         SUB,          32'h4,         1'b1,1'b0);
        add(1'b0,1'b0,32'h0,         1'b0,32'h0,       32'h0,         SW,           32'h8,         1'b1,1'b0);
        add(1'b0,1'b0,32'h0,         1'b0,32'h0,       32'h0,         LW,           32'hC,         1'b1,1'b0);
        // Misaligned and out-of-range fetches: 19..22
        add(1'b0,1'b1,32'h2,         1'b0,32'h0,       32'h0,         NOP,          32'hC,         1'b0,1'b0);
        add(1'b0,1'b0,32'h0,         1'b0,32'h0,       32'h0,         NOP,          32'h2,         1'b1,1'b1);
        add(1'b0,1'b1,32'h1000,      1'b0,32'h0,       32'h0,         NOP,          32'h2,         1'b0,1'b0);
        add(1'b0,1'b0,32'h0,         1'b0,32'h0,       32'h0,         NOP,          32'h1000,      1'b1,1'b1);
        // Load then fetch; load beats a simultaneous redirect: 23..27
        add(1'b0,1'b0,32'h0,         1'b1,32'h20,      32'hDEADBEEF,  NOP,          32'h1000,      1'b0,1'b0);
        add(1'b0,1'b1,32'h20,        1'b0,32'h0,       32'h0,         NOP,          32'h1000,      1'b0,1'b0);
        add(1'b0,1'b0,32'h0,         1'b0,32'h0,       32'h0,         32'hDEADBEEF, 32'h20,        1'b1,1'b0);
        add(1'b0,1'b1,32'h100,       1'b1,32'h24,      32'h12345678,  NOP,          32'h20,        1'b0,1'b0);
        add(1'b0,1'b0,32'h0,         1'b0,32'h0,       32'h0,         32'h12345678, 32'h24,        1'b1,1'b0);
        // Out-of-range load is dropped (would alias word 0 if truncated): 28..30
        add(1'b0,1'b0,32'h0,         1'b1,32'h4000,    32'hCAFEF00D,  NOP,          32'h24,        1'b0,1'b0);
        add(1'b0,1'b1,32'h0,         1'b0,32'h0,       32'h0,         NOP,          32'h24,        1'b0,1'b0);
        add(1'b0,1'b0,32'h0,         1'b0,32'h0,       32'h0,         ADD,          32'h0,         1'b1,1'b0);
        // PC wrap: 31..33
        add(1'b0,1'b1,32'hFFFFFFFC,  1'b0,32'h0,       32'h0,         NOP,          32'h0,         1'b0,1'b0);
        add(1'b0,1'b0,32'h0,         1'b0,32'h0,       32'h0,         NOP,          32'hFFFFFFFC,  1'b1,1'b1);
        add(1'b0,1'b0,32'h0,         1'b0,32'h0,       32'h0,         ADD,          32'h0,         1'b1,1'b0);

        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, NOP, 32'h0, 1'b0, 1'b0);
        reset = 1'b0;

        run_vecs("load", 0, 4);

        // Asynchronous reset between edges: outputs must clear before the next edge.
        @(posedge clk); #1;
        #2 reset = 1'b1;
        #1;
        chk_all("async_reset", 0, NOP, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;

        run_vecs("run", 5, 33);

        // Reset while a redirect is pending: target is discarded, fetch restarts at RESET_PC.
        redirect_valid = 1'b1; redirect_pc = 32'h80; stall = 1'b1;
        #1 reset = 1'b1;
        @(posedge clk); #1;
        chk_all("reset_redir", 0, NOP, 32'h0, 1'b0, 1'b0);
        idle_inputs();
        reset = 1'b0;
        @(posedge clk); #1;
        chk_all("reset_redir", 1, ADD, 32'h0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
